// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: hazard requests and imem word in, fetch address, IF/ID register and perf counters out.
// The slave side is the fetch unit; the master side is the hazard logic, imem and ID-stage consumers.
interface if_fetch_unit_if #(parameter int CNT_W = 16);
   logic              load_use_stall;
   logic              branch_taken;
   logic [31:0]       branch_target;
   logic              jump;
   logic [31:0]       jump_target;
   logic [31:0]       inst_in;
   logic [31:0]       imem_addr;
   logic [31:0]       ifid_inst;
   logic [31:0]       ifid_pc4;
   logic              ifid_valid;
   logic [1:0]        fetch_state;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output load_use_stall, branch_taken, branch_target, jump, jump_target, inst_in,
      input  imem_addr, ifid_inst, ifid_pc4, ifid_valid, fetch_state, stall_cnt, flush_cnt
   );

   modport slave (
      input  load_use_stall, branch_taken, branch_target, jump, jump_target, inst_in,
      output imem_addr, ifid_inst, ifid_pc4, ifid_valid, fetch_state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS fetch front end: PC register plus IF/ID register; one-edge fetch latency, redirect beats stall.
// Load-use stall freezes PC and IF/ID; all outputs are registered, nothing is combinational from inputs.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter bit          DELAY_SLOT = 1'b0,
   parameter int          CNT_W      = 16
) (
   input  logic            clk,
   input  logic            rst,
   if_fetch_unit_if.slave  bus
);
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state;
   logic [31:0]      pc;
   logic [31:0]      ifid_inst;
   logic [31:0]      ifid_pc4;
   logic             ifid_valid;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   logic [31:0] pc_plus4;
   logic        redirect;
   logic [31:0] redirect_pc;

   assign pc_plus4 = pc + 32'd4;
   assign redirect = bus.jump | bus.branch_taken;
   // Jump has priority over a simultaneous taken branch; targets are word aligned.
   assign redirect_pc = (bus.jump ? bus.jump_target : bus.branch_target) & ~32'd3;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         ifid_inst  <= 32'd0;
         ifid_pc4   <= 32'd0;
         ifid_valid <= 1'b0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         state      <= BOOT;
      end else if (redirect) begin
         pc <= redirect_pc;
         if (DELAY_SLOT) begin
            ifid_inst  <= bus.inst_in;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
         end else begin
            ifid_inst  <= 32'd0;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
         end
         if (flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
         state <= FLUSH;
      end else if (bus.load_use_stall) begin
         if (stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         state <= STALL;
      end else begin
         pc         <= pc_plus4;
         ifid_inst  <= bus.inst_in;
         ifid_pc4   <= pc_plus4;
         ifid_valid <= 1'b1;
         state      <= RUN;
      end
   end

   assign bus.imem_addr   = pc;
   assign bus.ifid_inst   = ifid_inst;
   assign bus.ifid_pc4    = ifid_pc4;
   assign bus.ifid_valid  = ifid_valid;
   assign bus.fetch_state = state;
   assign bus.stall_cnt   = stall_cnt;
   assign bus.flush_cnt   = flush_cnt;
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the five-stage pipelined MIPS CPU. It owns the PC register and the IF/ID pipeline register, and acts on the redirect and stall requests raised by the hazard logic. Those requests are jump, branch-taken with its target, and load-use stall. It presents the fetch address to the combinational instruction memory and hands the fetched word and PC+4 to the ID stage. It also keeps saturating stall and flush counters for performance checks.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded by reset; bits [1:0] must be 0.
- DELAY_SLOT, 0: 1 keeps the instruction fetched during a redirect (MIPS delay slot); 0 squashes it.
- CNT_W, 16: width of the performance counters.

- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- load_use_stall  in  1  hold PC and IF/ID (data hazard).
- branch_taken  in  1  branch resolved taken in ID this cycle.
- branch_target  in  32  branch destination.
- jump  in  1  J/JAL/JR in ID this cycle.
- jump_target  in  32  jump destination.
- inst_in  in  32  instruction word at imem_addr, combinational from instruction memory.
- imem_addr  out  32  current PC.
- ifid_inst  out  32  IF/ID instruction.
- ifid_pc4  out  32  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fetch_state  out  2  registered FSM state.
- stall_cnt  out  CNT_W  cycles spent in STALL.
- flush_cnt  out  CNT_W  redirects taken.

## Operation
- FSM states: BOOT=0, RUN=1, STALL=2, FLUSH=3. The state names the action taken at the last edge.
- Per-edge priority: rst, then redirect (jump or branch_taken), then load_use_stall, then normal advance.
- rst: pc <= RESET_PC. ifid_inst <= 0 (NOP). ifid_pc4 <= 0. ifid_valid <= 0. Both counters <= 0. State <= BOOT.
- Redirect:
  - pc <= jump ? jump_target : branch_target. Jump wins if both are asserted.
  - Target bits [1:0] are forced to 0.
  - DELAY_SLOT=0: IF/ID <= NOP, ifid_valid <= 0.
  - DELAY_SLOT=1: IF/ID loads inst_in and pc+4, ifid_valid <= 1.
  - flush_cnt += 1. State <= FLUSH.
- load_use_stall only: pc, ifid_inst, ifid_pc4 and ifid_valid are held. stall_cnt += 1. State <= STALL.
- Normal advance: pc <= pc+4. ifid_inst <= inst_in. ifid_pc4 <= pc+4. ifid_valid <= 1. State <= RUN.
- Arithmetic:
  - pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - Both counters saturate at all-ones and never wrap.
- imem_addr is the PC register itself, not a combinational next-PC.

## Timing
- Output values under reset: imem_addr=RESET_PC, ifid_inst=0, ifid_pc4=0, ifid_valid=0, fetch_state=BOOT, stall_cnt=0, flush_cnt=0.
- Fetch latency: the word at address A appears on ifid_inst 1 edge after imem_addr=A.
- Redirect asserted in cycle N:
  - imem_addr equals the target after edge N.
  - The target instruction is valid in IF/ID after edge N+1.
  - With DELAY_SLOT=0 exactly 1 bubble is inserted.
- Stall held for k cycles: PC and IF/ID are frozen k cycles, and stall_cnt rises by k.
- Redirect plus stall in the same cycle: the redirect executes and the stall is ignored. Only flush_cnt increments.
- rst asserted mid-stream: the reset values apply at that edge regardless of other inputs. Counters clear.
- The first edge after rst deasserts performs a normal advance from RESET_PC.
- Inputs are sampled only at the edge; no combinational path exists from inputs to outputs.

## Test plan
- Reset and free-run:
  - Stimulus: rst for 2 cycles, then inst_in = 32'h2000_0000 | addr for 4 cycles.
  - Required: imem_addr steps 0, 4, 8, 12. ifid_pc4 follows 4, 8, 12. ifid_valid=1 from the first post-reset edge. fetch_state=RUN.
- Load-use stall:
  - Stimulus: load_use_stall asserted 3 cycles at PC=0x10.
  - Required: imem_addr stays 0x10 and ifid_inst stays unchanged for 3 cycles. stall_cnt=3. State=STALL, then RUN after release.
- Branch redirect, DELAY_SLOT=0:
  - Stimulus: branch_taken with target 0x40 at PC=0x14.
  - Required: next imem_addr=0x40. ifid_valid=0 for 1 cycle. Then ifid_pc4=0x44. flush_cnt=1.
- Simultaneous events:
  - Stimulus: jump to 0x100, branch_taken to 0x200 and load_use_stall in the same cycle.
  - Required: imem_addr=0x100. stall_cnt unchanged. flush_cnt +1.
- DELAY_SLOT=1 and wrap:
  - Stimulus: a redirect at PC=0x20 with DELAY_SLOT=1. Separately, start from RESET_PC=32'hFFFF_FFFC.
  - Required: the redirect leaves ifid_valid=1 with ifid_pc4=0x24. The second run gives imem_addr=0 after one edge.
- Counter saturation and reset mid-run:
  - Stimulus: CNT_W=2 with 5 stall cycles, then rst pulsed during a stall.
  - Required: stall_cnt holds at 3. After the rst edge, all outputs equal their reset values.
